// File: rtl/second_tick.sv
// second_tick: combinational in0 & ~in1 gate with a registered shadow,
// a registered rising-edge pulse and a saturating count of asserted edges.
module second_tick #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in0,
    input  logic             in1,
    output logic             out,
    output logic             out_q,
    output logic             out_rise,
    output logic [CNT_W-1:0] tick_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic cnt_sat;

    // Gate stays outside any clocked or reset logic so it tracks inputs instantly.
    assign out     = in0 & ~in1;
    assign cnt_sat = (tick_cnt == CNT_MAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q    <= 1'b0;
            out_rise <= 1'b0;
            tick_cnt <= '0;
        end else begin
            out_q    <= out;
            out_rise <= out & ~out_q;
            if (out && !cnt_sat) begin
                tick_cnt <= tick_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_second_tick.sv
// Directed bench for second_tick: a default-width instance and a 3-bit counter
// instance share stimulus so saturation is exercised alongside normal counting.
module tb_second_tick;

    logic        clk;
    logic        rst;
    logic        in0;
    logic        in1;
    logic        out;
    logic        out_q;
    logic        out_rise;
    logic [15:0] tick_cnt;
    logic        s_out;
    logic        s_out_q;
    logic        s_out_rise;
    logic [2:0]  s_tick_cnt;

    int n_pass  = 0;
    int n_total = 0;
    int rises;

    second_tick #(.CNT_W(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .in0      (in0),
        .in1      (in1),
        .out      (out),
        .out_q    (out_q),
        .out_rise (out_rise),
        .tick_cnt (tick_cnt)
    );

    second_tick #(.CNT_W(3)) dut_s (
        .clk      (clk),
        .rst      (rst),
        .in0      (in0),
        .in1      (in1),
        .out      (s_out),
        .out_q    (s_out_q),
        .out_rise (s_out_rise),
        .tick_cnt (s_tick_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one clock; sample 1 time unit after the rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        in0 = 1'b0;
        in1 = 1'b0;

        // Combinational sweep, 2 time units per step.
        #2; chk("comb_00", out, 0); chk("comb_00_s", s_out, 0);
        in0 = 1; in1 = 0;
        #2; chk("comb_10", out, 1); chk("comb_10_s", s_out, 1);
        in0 = 0; in1 = 1;
        #2; chk("comb_01", out, 0);
        in0 = 1; in1 = 1;
        #2; chk("comb_11", out, 0);

        // Reset for 2 cycles with gate open.
        in0 = 1; in1 = 0;
        cyc(); cyc();
        chk("rst_out", out, 1);
        chk("rst_out_q", out_q, 0);
        chk("rst_rise", out_rise, 0);
        chk("rst_cnt", tick_cnt, 0);
        chk("rst_cnt_s", s_tick_cnt, 0);

        // Release and hold (1,0) for 5 cycles.
        rst   = 0;
        rises = 0;
        for (int i = 1; i <= 5; i++) begin
            cyc();
            if (out_rise) rises++;
            chk("hold_cnt", tick_cnt, i);
            chk("hold_out_q", out_q, 1);
            chk("hold_rise", out_rise, (i == 1) ? 1 : 0);
        end
        chk("hold_rises", rises, 1);
        chk("hold_cnt_s", s_tick_cnt, 5);

        // Inhibit for 3 cycles: counter holds.
        in1 = 1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("inh_cnt", tick_cnt, 5);
            chk("inh_out_q", out_q, 0);
            chk("inh_rise", out_rise, 0);
        end

        // Alternate (1,0)/(1,1) for 8 cycles.
        rises = 0;
        for (int i = 0; i < 8; i++) begin
            in1 = (i % 2 == 1);
            cyc();
            if (out_rise) rises++;
            chk("alt_out_q", out_q, (i % 2 == 0) ? 1 : 0);
        end
        chk("alt_rises", rises, 4);
        chk("alt_cnt", tick_cnt, 9);
        chk("alt_cnt_s", s_tick_cnt, 7);

        // Clean reset, then count to 5.
        in1 = 0;
        rst = 1;
        cyc();
        chk("rst2_cnt", tick_cnt, 0);
        chk("rst2_cnt_s", s_tick_cnt, 0);
        rst = 0;
        for (int i = 1; i <= 5; i++) begin
            cyc();
            chk("pre_cnt", tick_cnt, i);
        end

        // Mid-operation reset with gate still open.
        rst = 1;
        cyc();
        chk("mid_cnt", tick_cnt, 0);
        chk("mid_out_q", out_q, 0);
        chk("mid_rise", out_rise, 0);
        chk("mid_cnt_s", s_tick_cnt, 0);
        rst = 0;

        // After release: resume from 0; 3-bit instance saturates at 7.
        for (int i = 1; i <= 10; i++) begin
            cyc();
            chk("post_cnt", tick_cnt, i);
            chk("sat_cnt_s", s_tick_cnt, (i < 7) ? i : 7);
            if (i == 1) begin
                chk("post_rise", out_rise, 1);
                chk("post_rise_s", s_out_rise, 1);
            end
        end
        chk("sat_final_s", s_tick_cnt, 7);
        chk("sat_out_q_s", s_out_q, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
